pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised pipeline stage register for the five-stage CPU that replaces the fixed, always-advancing inter-stage latches (ID/EXE first, then EXE/MEM and MEM/WB). It carries a control field and a data field between stages under a valid/ready handshake. A two-entry skid buffer keeps the upstream ready free of any combinational path from downstream ready. Synchronous flush turns in-flight entries into bubbles, and a saturating counter records back-pressure cycles for performance analysis.

## Interface
- CTRL_W, 8: control field width, zeroed on bubble/flush (ID/EXE packing: m2reg, wmem, aluc[2:0], aluimm, shift, wreg).
- DATA_W, 101: data field width (ID/EXE packing: ra, rb, imm, rn).
- CLEAR_DATA, 0: 1 = data field also zeroed on flush; 0 = data field retained.
- CNT_W, 16: stall counter width.

- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  reset, asynchronous, active-low; clock clk.
- flush  in  1  synchronous flush (branch/jump squash), highest priority.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- out_ctrl  out  CTRL_W  control of head entry; all-zero whenever out_valid=0.
- out_data  out  DATA_W  data of head entry; holds last value when out_valid=0.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating.

## Operation
- Storage: main register (drives outputs) plus skid register; each has its own valid bit.
- States: EMPTY (none), ONE (main only), FULL (main + skid). occupancy encodes the state: EMPTY=0, ONE=1, FULL=2.
- in_ready = !skid_valid. It is 1 in EMPTY and ONE and 0 in FULL. It depends only on registered state.
- Transitions when flush=0:
  - EMPTY: if in_xfer, main <= in and go to ONE; otherwise stay.
  - ONE: on in_xfer && out_xfer, main <= in and stay in ONE. On in_xfer only, skid <= in and go to FULL. On out_xfer only, go to EMPTY.
  - FULL: on out_xfer, main <= skid and go to ONE; otherwise stay (no input accepted).
- Order is preserved: skid content is always younger than main content.
- flush=1: next state is EMPTY, regardless of in/out transfers that cycle. Main and skid ctrl are zeroed. Data is zeroed only if CLEAR_DATA=1. An input transfer in the flush cycle is discarded. An output transfer in the flush cycle still completes downstream, since outputs are registered.
- out_ctrl is the registered main ctrl gated by out_valid, so a bubble never asserts wmem or wreg.
- stall_cnt increments by 1 in each cycle with out_valid=1 && out_ready=0, and stops at 2^CNT_W-1. Only reset clears it; flush does not.

## Timing
- Reset (clrn=0, asynchronous): state EMPTY, out_valid=0, in_ready=1 on release, out_ctrl=0, out_data=0, skid cleared, occupancy=0, stall_cnt=0.
- Latency: an input accepted in cycle n appears on out_* in cycle n+1 when the stage was EMPTY, or when it was ONE with out_xfer in cycle n.
- Throughput: 1 entry/cycle with out_ready held high; no bubbles are inserted.
- Back-pressure: out_ready dropping costs at most one extra accepted entry, which goes to skid. in_ready falls one cycle later.
- Release from FULL: in_ready returns to 1 the cycle after the out_xfer that drains main.
- All outputs are registered or derived purely from registers, with no input-to-output combinational path.
- Reset asserted mid-transfer: all entries are lost immediately and the stage is EMPTY after release.

## Test plan
- Streaming: out_ready=1, in_valid=1 for 8 cycles with data 1..8. Required: out_data 1..8 on consecutive cycles starting 1 cycle after the first accept, occupancy never above 1, stall_cnt=0.
- Back-pressure: stream entries 1,2,3 with out_ready=0 from cycle 2. Required: occupancy reaches 2, in_ready=0, entry 3 is held upstream, stall_cnt increments each cycle. After raising out_ready, out_data shows 1,2,3 in order with no loss or duplicate.
- Flush in FULL: with CTRL=8'hFF entries in both main and skid, pulse flush with in_valid=1. Required next cycle: out_valid=0, out_ctrl=0, occupancy=0, and the input offered in the flush cycle never appears. With CLEAR_DATA=0 out_data is unchanged; with CLEAR_DATA=1 it is 0.
- Bubble control: in_valid=0 while the stage is idle after a transfer. Required: out_ctrl=0 on every idle cycle while out_data retains the last value.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles. Required: stall_cnt stops at 15. A subsequent flush leaves it at 15; clrn=0 clears it to 0.
- Async reset mid-stream: assert clrn=0 between clock edges while FULL. Required: outputs go to reset values immediately, before the next edge, with occupancy=0 and in_ready=1 after release.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage register with two-entry skid buffer
//
// Purpose:
//   Inter-stage register for the five-stage CPU. It moves a control field and
//   a data field under a valid/ready handshake. A skid register absorbs the
//   one extra entry accepted after out_ready drops. Because of this, in_ready
//   depends only on registered state. Flush squashes all held entries into
//   bubbles. A saturating counter records back-pressure cycles.
//
// Parameters:
//   CTRL_W     control field width, zeroed on bubble/flush
//   DATA_W     data field width
//   CLEAR_DATA 1 = data also zeroed on flush, 0 = data retained
//   CNT_W      stall counter width
//
// Ports:
//   clk        clock, rising edge
//   clrn       asynchronous active-low reset
//   flush      synchronous squash, highest priority
//   in_valid   upstream entry present
//   in_ready   stage can accept (registered: !skid_valid)
//   in_ctrl    upstream control field
//   in_data    upstream data field
//   out_valid  head entry presented downstream
//   out_ready  downstream accepts
//   out_ctrl   head control, all-zero while out_valid=0
//   out_data   head data, holds last value while out_valid=0
//   occupancy  entries held (0, 1, 2)
//   stall_cnt  saturating count of out_valid && !out_ready cycles

module pipe_stage_skid #(
   parameter int CTRL_W     = 8,
   parameter int DATA_W     = 101,
   parameter int CLEAR_DATA = 0,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state;
   state_t state_nxt;

   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   logic main_valid;
   logic skid_valid;
   logic in_xfer;
   logic out_xfer;

   logic load_main_in;
   logic load_main_skid;
   logic load_skid_in;

   // Valid bits are decoded from the state register, so they are registered too.
   assign main_valid = (state != EMPTY);
   assign skid_valid = (state == FULL);

   assign in_ready  = !skid_valid;
   assign out_valid = main_valid;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   // Gate ctrl so a bubble can never assert write enables downstream.
   assign out_ctrl  = main_valid ? main_ctrl : '0;
   assign out_data  = main_data;
   assign occupancy = skid_valid ? 2'd2 : (main_valid ? 2'd1 : 2'd0);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  load_main_in = 1'b1;
                  state_nxt    = ONE;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  load_main_in = 1'b1;
               end else if (in_xfer) begin
                  // Downstream stalled: park the younger entry behind main.
                  load_skid_in = 1'b1;
                  state_nxt    = FULL;
               end else if (out_xfer) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only the drain of main can happen.
               if (out_xfer) begin
                  load_main_skid = 1'b1;
                  state_nxt      = ONE;
               end
            end
            default: begin
               state_nxt = EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         main_ctrl <= '0;
         main_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else if (flush) begin
         main_ctrl <= '0;
         skid_ctrl <= '0;
         if (CLEAR_DATA != 0) begin
            main_data <= '0;
            skid_data <= '0;
         end
      end else begin
         if (load_main_in) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
         end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
         end
         if (load_skid_in) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
         end
      end
   end

   // Counts every stalled cycle, including a flush cycle. Only reset clears it.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
